dfr_hybrid_core_top: RTL and testbench
======================================

// Module: dfr_hybrid_core_top
// PURPOSE
//  AXI4-Lite-controlled delayed-feedback-reservoir (DFR) engine: config registers plus four word memories
//  (input, reservoir history, weights, DFR output). On start, runs a digital reservoir over the input stream,
//  stores node states, and writes one weighted-sum output per test sample. Sits as an AXI slave under the PS.
// PARAMETERS
//  C_S_AXI_ACLK_FREQ_HZ 100000000  clock frequency, informational only
//  C_S_AXI_DATA_WIDTH 32  AXI data width; also memory word width
//  C_S_AXI_ADDR_WIDTH 16  AXI byte-address width
//  VIRTUAL_NODES 10  reservoir delay-loop length (steps)
//  RESERVOIR_DATA_WIDTH 32  reservoir/weight/output signed word width
//  RESERVOIR_HISTORY_ADDR_WIDTH 16  width of step/sample counters
// PORTS
//  S_AXI_ACLK  in 1  sole clock
//  S_AXI_ARESETN  in 1  reset: synchronous, active-high (name kept from the AXI convention)
//  S_AXI_AWADDR/AWVALID/AWREADY  in/in/out 16/1/1  write address channel
//  S_AXI_WDATA/WSTRB/WVALID/WREADY  in/in/in/out 32/4/1/1  write data channel (WSTRB ignored)
//  S_AXI_BRESP/BVALID/BREADY  out/out/in 2/1/1  write response (BRESP always 2'b00)
//  S_AXI_ARADDR/ARVALID/ARREADY  in/in/out 16/1/1  read address channel
//  S_AXI_RDATA/RRESP/RVALID/RREADY  out/out/out/in 32/2/1/1  read data (RRESP always 2'b00)
//  busy  out 1  high from accepted start until final output written
// BEHAVIOUR
//  Reset: all AXI outputs 0, busy 0, all registers 0, FSM IDLE. Memory contents undefined.
//  Write: when AWVALID&WVALID, pulse AWREADY=WREADY=1 one cycle; next cycle BVALID=1, held until BREADY.
//  Read: when ARVALID and RVALID=0, pulse ARREADY one cycle; next cycle RVALID=1 with RDATA, held until RREADY.
//  Map (addr[15:8]=0x00): 0x00 CTRL, 0x04 DEBUG, 0x08 INIT_SAMPLES, 0x0C TRAIN_SAMPLES, 0x10 TEST_SAMPLES,
//   0x14 STEPS_PER_SAMPLE, 0x18 INIT_STEPS, 0x1C TRAIN_STEPS, 0x20 TEST_STEPS; all 32-bit R/W; others read 0.
//  CTRL: bit0 start (self-clears next cycle, reads 0); bit1 reads busy (RO); bits[5:4] mem select
//   0 input,1 reservoir,2 weight,3 output; other bits plain storage.
//  addr[15:8]=0x01: access selected memory, word index = addr[7:0] (byte-granular index, 256 words each).
//  While busy: AXI memory writes dropped, memory reads return 0, start ignored; register writes allowed.
//  FSM: IDLE -> (start) FETCH -> STEP -> [ACCUM] -> back to FETCH or DONE -> IDLE. busy=1 outside IDLE.
//   Total steps T = INIT_STEPS+TRAIN_STEPS+TEST_STEPS; T=0 -> busy one cycle, no memory writes.
//   Step s (0..T-1): r[s] = (in[s] + (s>=VIRTUAL_NODES ? r[s-VIRTUAL_NODES] : 0)) >>> 1, 32-bit signed,
//    sum wraps mod 2^32 before shift; r[s] written to reservoir mem[s mod 256].
//   Test steps (s >= INIT+TRAIN steps), k = position within sample (0..STEPS_PER_SAMPLE-1):
//    acc += weight[k]*r[s], low 32 bits kept; on k=STEPS_PER_SAMPLE-1 write acc to output mem[sample], clear acc.
//   Outputs stop after TEST_SAMPLES writes; sample index wraps at 256. STEPS_PER_SAMPLE=0 treated as 1.
//  Reset mid-run: FSM to IDLE, busy 0 next cycle, accumulator cleared; memories keep partial results.
// TESTING
//  Write 0xDEADBEEE to CTRL, read back -> 0xDEADBEEC with bits[1:0] masked; CTRL sel bits read back.
//  Each mem select: write i to 0x0100+i, read back i (input i<100; others i<16).
//  TEST_SAMPLES=5, STEPS_PER_SAMPLE=10, TEST_STEPS=50, others 0; in[i]=i*335544, in[50..59]=0, weight[0..49]=1;
//   CTRL=1 -> busy falls; output[0] = 45*167772 = 7549740.
//  Same run: reservoir mem[3] = 503316; mem[13] = (13*335544 + 503316)>>>1 = 2432694.
//  Start while busy, or mem write while busy -> ignored; results unchanged.
//  Assert reset mid-run -> busy=0 next cycle; fresh start completes normally.

Source files
------------

// File: rtl/dfr_hybrid_core_top.sv
// Delayed-feedback-reservoir engine behind an AXI4-Lite slave.
// The register page (0x00xx) holds the run configuration. The memory page
// (0x01xx) reaches one of four 256-word memories: input, reservoir history,
// weights and outputs. A start command runs the reservoir recurrence over the
// input stream and writes the node states to the history memory. During the
// test phase it also produces one weighted-sum output per sample.
module dfr_hybrid_core_top #(
  parameter int C_S_AXI_ACLK_FREQ_HZ         = 100000000,
  parameter int C_S_AXI_DATA_WIDTH           = 32,
  parameter int C_S_AXI_ADDR_WIDTH           = 16,
  parameter int VIRTUAL_NODES                = 10,
  parameter int RESERVOIR_DATA_WIDTH         = 32,
  parameter int RESERVOIR_HISTORY_ADDR_WIDTH = 16
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            busy
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int RW = RESERVOIR_DATA_WIDTH;
  localparam int HW = RESERVOIR_HISTORY_ADDR_WIDTH;

  // The clock frequency is informational only; this empty block just names it.
  if (C_S_AXI_ACLK_FREQ_HZ < 0) begin : g_freq_info
  end

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_STEP  = 3'd2,
    ST_ACCUM = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  logic clk;
  logic rst;
  assign clk = S_AXI_ACLK;
  assign rst = S_AXI_ARESETN;  // active-high despite the AXI-style name

  // ---------------- AXI handshake state ----------------
  logic aw_ready;
  logic b_valid;
  logic ar_ready;
  logic r_valid;
  logic [DW-1:0] r_data;

  assign S_AXI_AWREADY = aw_ready;
  assign S_AXI_WREADY  = aw_ready;
  assign S_AXI_BVALID  = b_valid;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = ar_ready;
  assign S_AXI_RVALID  = r_valid;
  assign S_AXI_RDATA   = r_data;
  assign S_AXI_RRESP   = 2'b00;

  // ---------------- configuration registers ----------------
  logic [DW-1:2] ctrl;  // bits 1:0 are start/busy and are never stored
  logic [DW-1:0] debug_reg;
  logic [DW-1:0] init_samples;
  logic [DW-1:0] train_samples;
  logic [DW-1:0] test_samples;
  logic [DW-1:0] steps_per_sample;
  logic [DW-1:0] init_steps;
  logic [DW-1:0] train_steps;
  logic [DW-1:0] test_steps;
  logic          start_pulse;

  // ---------------- memories ----------------
  logic [DW-1:0] input_mem  [256];
  logic [DW-1:0] res_mem    [256];
  logic [DW-1:0] weight_mem [256];
  logic [DW-1:0] out_mem    [256];

  // ---------------- core state ----------------
  state_t        state;
  state_t        next_state;
  logic [HW-1:0] step;
  logic [HW-1:0] k_pos;
  logic [HW-1:0] sample;
  logic [RW-1:0] acc;
  logic [RW-1:0] in_word;
  logic [RW-1:0] fb_word;
  logic [RW-1:0] w_word;
  logic [RW-1:0] r_word;

  // ---------------- decode ----------------
  logic       wr_fire;
  logic       reg_wr;
  logic       mem_wr;
  logic [7:0] wr_off;
  logic [7:0] rd_off;
  logic [1:0] mem_sel;

  // A write takes effect on the cycle AWREADY/WREADY are high.
  assign wr_fire = aw_ready && S_AXI_AWVALID && S_AXI_WVALID;
  assign wr_off  = S_AXI_AWADDR[7:0];
  assign rd_off  = S_AXI_ARADDR[7:0];
  assign reg_wr  = wr_fire && (S_AXI_AWADDR[15:8] == 8'h00);
  assign mem_wr  = wr_fire && (S_AXI_AWADDR[15:8] == 8'h01) && !busy;
  assign mem_sel = ctrl[5:4];

  // ---------------- datapath helpers ----------------
  logic [DW-1:0]        total_full;
  logic [DW-1:0]        test_start_full;
  logic [HW-1:0]        total_steps;
  logic [HW-1:0]        test_start;
  logic [DW-1:0]        spw_eff;
  logic                 is_test;
  logic                 step_last;
  logic                 k_last;
  logic                 sample_ok;
  logic                 has_feedback;
  logic [7:0]           fb_idx;
  logic signed [RW-1:0] sum_word;
  logic [RW-1:0]        r_val;
  logic [RW-1:0]        prod;
  logic [RW-1:0]        acc_next;
  logic                 out_we;

  assign total_full      = init_steps + train_steps + test_steps;
  assign test_start_full = init_steps + train_steps;
  assign total_steps     = total_full[HW-1:0];
  assign test_start      = test_start_full[HW-1:0];
  assign spw_eff         = (steps_per_sample == {DW{1'b0}}) ? {{(DW-1){1'b0}}, 1'b1} : steps_per_sample;
  assign is_test         = (step >= test_start);
  assign step_last       = ((step + HW'(1)) == total_steps);
  assign k_last          = ((DW'(k_pos) + DW'(1)) == spw_eff);
  assign sample_ok       = (DW'(sample) < test_samples);
  assign has_feedback    = (step >= HW'(VIRTUAL_NODES));
  assign fb_idx          = step[7:0] - 8'(VIRTUAL_NODES);
  // Sum wraps at the word width before the arithmetic halving.
  assign sum_word        = in_word + fb_word;
  assign r_val           = sum_word >>> 1;
  assign prod            = w_word * r_word;
  assign acc_next        = acc + prod;
  assign out_we          = (state == ST_ACCUM) && k_last && sample_ok;

  logic unused_bits;
  assign unused_bits = ^{S_AXI_WSTRB, S_AXI_WDATA[1], total_full[DW-1:HW], test_start_full[DW-1:HW]};

  // Write channel: accept address+data together, then hold BVALID until BREADY.
  always_ff @(posedge clk) begin
    if (rst) begin
      aw_ready <= 1'b0;
      b_valid  <= 1'b0;
    end else if (aw_ready) begin
      aw_ready <= 1'b0;
      b_valid  <= 1'b1;
    end else if (b_valid) begin
      if (S_AXI_BREADY) b_valid <= 1'b0;
    end else if (S_AXI_AWVALID && S_AXI_WVALID) begin
      aw_ready <= 1'b1;
    end
  end

  // Register file writes and the one-cycle start command.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl             <= '0;
      debug_reg        <= '0;
      init_samples     <= '0;
      train_samples    <= '0;
      test_samples     <= '0;
      steps_per_sample <= '0;
      init_steps       <= '0;
      train_steps      <= '0;
      test_steps       <= '0;
      start_pulse      <= 1'b0;
    end else begin
      start_pulse <= 1'b0;
      if (reg_wr) begin
        case (wr_off)
          8'h00: begin
            ctrl <= S_AXI_WDATA[DW-1:2];
            if (S_AXI_WDATA[0] && !busy) start_pulse <= 1'b1;
          end
          8'h04: debug_reg        <= S_AXI_WDATA;
          8'h08: init_samples     <= S_AXI_WDATA;
          8'h0C: train_samples    <= S_AXI_WDATA;
          8'h10: test_samples     <= S_AXI_WDATA;
          8'h14: steps_per_sample <= S_AXI_WDATA;
          8'h18: init_steps       <= S_AXI_WDATA;
          8'h1C: train_steps      <= S_AXI_WDATA;
          8'h20: test_steps       <= S_AXI_WDATA;
          default: ;
        endcase
      end
    end
  end

  // Input memory: host-written only.
  always_ff @(posedge clk) begin
    if (mem_wr && (mem_sel == 2'd0)) input_mem[wr_off] <= S_AXI_WDATA;
  end

  // Weight memory: host-written only.
  always_ff @(posedge clk) begin
    if (mem_wr && (mem_sel == 2'd2)) weight_mem[wr_off] <= S_AXI_WDATA;
  end

  // Reservoir history: the core writes while busy, the host only while idle.
  always_ff @(posedge clk) begin
    if (state == ST_STEP) res_mem[step[7:0]] <= r_val;
    else if (mem_wr && (mem_sel == 2'd1)) res_mem[wr_off] <= S_AXI_WDATA;
  end

  // Output memory: the core writes finished samples, the host only while idle.
  always_ff @(posedge clk) begin
    if (out_we) out_mem[sample[7:0]] <= acc_next;
    else if (mem_wr && (mem_sel == 2'd3)) out_mem[wr_off] <= S_AXI_WDATA;
  end

  // Read data mux: registers, or the selected memory (zero while busy).
  logic [DW-1:0] rd_value;
  always_comb begin
    rd_value = '0;
    if (S_AXI_ARADDR[15:8] == 8'h00) begin
      case (rd_off)
        8'h00:   rd_value = {ctrl, busy, 1'b0};
        8'h04:   rd_value = debug_reg;
        8'h08:   rd_value = init_samples;
        8'h0C:   rd_value = train_samples;
        8'h10:   rd_value = test_samples;
        8'h14:   rd_value = steps_per_sample;
        8'h18:   rd_value = init_steps;
        8'h1C:   rd_value = train_steps;
        8'h20:   rd_value = test_steps;
        default: rd_value = '0;
      endcase
    end else if ((S_AXI_ARADDR[15:8] == 8'h01) && !busy) begin
      case (mem_sel)
        2'd0:    rd_value = input_mem[rd_off];
        2'd1:    rd_value = res_mem[rd_off];
        2'd2:    rd_value = weight_mem[rd_off];
        2'd3:    rd_value = out_mem[rd_off];
        default: rd_value = '0;
      endcase
    end else begin
      rd_value = '0;
    end
  end

  // Read channel: pulse ARREADY, then present RDATA until RREADY.
  always_ff @(posedge clk) begin
    if (rst) begin
      ar_ready <= 1'b0;
      r_valid  <= 1'b0;
      r_data   <= '0;
    end else if (ar_ready) begin
      ar_ready <= 1'b0;
      r_valid  <= 1'b1;
      r_data   <= rd_value;
    end else if (r_valid) begin
      if (S_AXI_RREADY) r_valid <= 1'b0;
    end else if (S_AXI_ARVALID) begin
      ar_ready <= 1'b1;
    end
  end

  // Sequencer next-state: fetch operands, compute the node, accumulate in test steps.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (start_pulse) next_state = (total_steps == {HW{1'b0}}) ? ST_DONE : ST_FETCH;
        else next_state = ST_IDLE;
      end
      ST_FETCH: next_state = ST_STEP;
      ST_STEP: begin
        if (is_test) next_state = ST_ACCUM;
        else if (step_last) next_state = ST_DONE;
        else next_state = ST_FETCH;
      end
      ST_ACCUM: begin
        if (step_last) next_state = ST_DONE;
        else next_state = ST_FETCH;
      end
      ST_DONE:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Sequencer state, counters, operand latches and the output accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      step    <= '0;
      k_pos   <= '0;
      sample  <= '0;
      acc     <= '0;
      in_word <= '0;
      fb_word <= '0;
      w_word  <= '0;
      r_word  <= '0;
    end else begin
      state <= next_state;
      busy  <= (next_state != ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (start_pulse) begin
            step   <= '0;
            k_pos  <= '0;
            sample <= '0;
            acc    <= '0;
          end
        end
        ST_FETCH: begin
          in_word <= input_mem[step[7:0]];
          fb_word <= has_feedback ? res_mem[fb_idx] : {RW{1'b0}};
          w_word  <= weight_mem[k_pos[7:0]];
        end
        ST_STEP: begin
          r_word <= r_val;
          if (!is_test) step <= step + HW'(1);
        end
        ST_ACCUM: begin
          step <= step + HW'(1);
          if (k_last) begin
            acc    <= '0;
            k_pos  <= '0;
            sample <= sample + HW'(1);
          end else begin
            acc   <= acc_next;
            k_pos <= k_pos + HW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dfr_hybrid_core_top.sv
// Self-checking bench for dfr_hybrid_core_top: AXI register/memory access,
// directed and randomized reservoir runs checked against an array model.
module tb_dfr_hybrid_core_top;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] awaddr = 16'h0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = 32'h0;
  logic [3:0]  wstrb = 4'hF;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b1;
  logic [15:0] araddr = 16'h0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b1;
  logic        busy;

  int compared = 0;
  int mismatched = 0;
  int busy_cycles = 0;

  logic [31:0] m_in  [256];
  logic [31:0] m_w   [256];
  logic [31:0] m_r   [256];
  logic [31:0] m_out [256];
  int          m_total;
  int          m_nout;

  dfr_hybrid_core_top dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (busy === 1'b1) busy_cycles <= busy_cycles + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [15:0] a, input logic [31:0] d);
    int n;
    @(negedge clk);
    awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    while (awready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (awready !== 1'b1) check("aw_timeout", {31'b0, awready}, 32'd1);
    check("wready", {31'b0, wready}, 32'd1);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    check("bvalid_bresp", {29'b0, bresp, bvalid}, 32'd1);
    @(negedge clk);
  endtask

  task automatic axi_read(input logic [15:0] a, output logic [31:0] d);
    int n;
    @(negedge clk);
    araddr = a; arvalid = 1'b1;
    n = 0;
    while (arready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (arready !== 1'b1) check("ar_timeout", {31'b0, arready}, 32'd1);
    @(negedge clk);
    arvalid = 1'b0;
    if (rvalid !== 1'b1 || rresp !== 2'b00) check("rvalid_rresp", {29'b0, rresp, rvalid}, 32'd1);
    d = rdata;
    @(negedge clk);
  endtask

  task automatic read_check(input string tag, input logic [15:0] a, input logic [31:0] exp);
    logic [31:0] d;
    axi_read(a, d);
    check(tag, d, exp);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin @(negedge clk); n++; end
    check("busy_timeout", {31'b0, busy}, 32'd0);
  endtask

  task automatic select_mem(input int sel);
    axi_write(16'h0000, 32'(sel) << 4);
  endtask

  task automatic load_inputs(input int count);
    select_mem(0);
    for (int i = 0; i < count; i++) axi_write(16'h0100 + 16'(i), m_in[i]);
  endtask

  task automatic load_weights(input int count);
    select_mem(2);
    for (int i = 0; i < count; i++) axi_write(16'h0100 + 16'(i), m_w[i]);
  endtask

  task automatic configure(input int ist, input int tst, input int xst, input int spw, input int tsm);
    axi_write(16'h0008, $urandom);
    axi_write(16'h000C, $urandom);
    axi_write(16'h0010, 32'(tsm));
    axi_write(16'h0014, 32'(spw));
    axi_write(16'h0018, 32'(ist));
    axi_write(16'h001C, 32'(tst));
    axi_write(16'h0020, 32'(xst));
  endtask

  // Reference: node recurrence over the whole stream, then one dot product
  // per complete test sample, capped at the requested sample count.
  task automatic run_model(input int ist, input int tst, input int xst, input int spw, input int tsm);
    logic [31:0]        fb;
    logic signed [31:0] sum;
    logic [31:0]        acc;
    int                 spe;
    int                 ts;
    m_total = ist + tst + xst;
    for (int s = 0; s < m_total; s++) begin
      fb = (s >= 10) ? m_r[s - 10] : 32'd0;
      sum = m_in[s % 256] + fb;
      m_r[s] = sum >>> 1;
    end
    spe = (spw == 0) ? 1 : spw;
    ts = ist + tst;
    m_nout = 0;
    while (ts + (m_nout + 1) * spe <= m_total && m_nout < tsm) begin
      acc = 32'd0;
      for (int k = 0; k < spe; k++) acc = acc + m_w[k] * m_r[ts + m_nout * spe + k];
      m_out[m_nout] = acc;
      m_nout++;
    end
  endtask

  task automatic check_results();
    select_mem(1);
    for (int s = 0; s < m_total; s++)
      read_check($sformatf("res[%0d]", s), 16'h0100 + 16'(s), m_r[s]);
    select_mem(3);
    for (int n = 0; n < m_nout; n++)
      read_check($sformatf("out[%0d]", n), 16'h0100 + 16'(n), m_out[n]);
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] regv [9];
    int          bc0;
    int          ist, tst, xst, spw, tsm;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_axi_outs", {23'b0, awready, wready, bvalid, bresp, arready, rvalid, rresp, busy}, 32'd0);
    check("reset_rdata", rdata, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 9; i++) read_check($sformatf("reg_reset[%0d]", i), 16'(i * 4), 32'd0);
    read_check("unmapped_reg", 16'h0024, 32'd0);

    // CTRL storage, start/busy bits masked
    axi_write(16'h0000, 32'hDEADBEEE);
    read_check("ctrl_readback", 16'h0000, 32'hDEADBEEC);
    axi_read(16'h0000, d);
    check("ctrl_sel", d & 32'h30, 32'h20);

    // Plain R/W registers with random data
    for (int i = 1; i < 9; i++) begin
      regv[i] = $urandom;
      axi_write(16'(i * 4), regv[i]);
    end
    for (int i = 1; i < 9; i++) read_check($sformatf("reg_rw[%0d]", i), 16'(i * 4), regv[i]);

    // Memory access per select
    for (int sel = 0; sel < 4; sel++) begin
      int lim;
      lim = (sel == 0) ? 100 : 16;
      select_mem(sel);
      for (int i = 0; i < lim; i++) axi_write(16'h0100 + 16'(i), 32'(i));
      for (int i = 0; i < lim; i++) read_check($sformatf("mem%0d[%0d]", sel, i), 16'h0100 + 16'(i), 32'(i));
    end

    // Directed run: 5 samples of 10 steps, unit weights
    for (int i = 0; i < 60; i++) m_in[i] = (i < 50) ? 32'(i * 335544) : 32'd0;
    for (int i = 0; i < 50; i++) m_w[i] = 32'd1;
    load_inputs(60);
    load_weights(50);
    configure(0, 0, 50, 10, 5);
    run_model(0, 0, 50, 10, 5);
    axi_write(16'h0000, 32'h1);
    check("busy_after_start", {31'b0, busy}, 32'd1);
    read_check("ctrl_busy_bit", 16'h0000, 32'h2);
    read_check("mem_read_busy", 16'h0105, 32'd0);
    axi_write(16'h0105, 32'hBAD0BAD0);
    axi_write(16'h0000, 32'h1);
    wait_idle(2000);
    select_mem(0);
    read_check("mem_write_dropped", 16'h0105, m_in[5]);
    check_results();
    select_mem(3);
    read_check("spec_out0", 16'h0100, 32'd7549740);
    select_mem(1);
    read_check("spec_res3", 16'h0103, 32'd503316);
    read_check("spec_res13", 16'h010D, 32'd2432694);

    // Zero-length run: busy one cycle, outputs untouched
    configure(0, 0, 0, 10, 5);
    bc0 = busy_cycles;
    axi_write(16'h0000, 32'h1);
    wait_idle(100);
    check("t0_busy_cycles", 32'(busy_cycles - bc0), 32'd1);
    select_mem(3);
    read_check("t0_out0_kept", 16'h0100, m_out[0]);

    // Randomized runs
    for (int it = 0; it < 4; it++) begin
      ist = $urandom_range(0, 15);
      tst = $urandom_range(0, 15);
      xst = $urandom_range(0, 50);
      spw = (it == 2) ? 0 : $urandom_range(1, 8);
      tsm = $urandom_range(1, 6);
      for (int i = 0; i < ist + tst + xst; i++) m_in[i] = $urandom;
      for (int i = 0; i < 8; i++) m_w[i] = $urandom;
      load_inputs(ist + tst + xst);
      load_weights(8);
      configure(ist, tst, xst, spw, tsm);
      run_model(ist, tst, xst, spw, tsm);
      axi_write(16'h0000, 32'h1);
      wait_idle(3000);
      check_results();
    end

    // Reset mid-run, then a fresh run completes
    for (int i = 0; i < 150; i++) m_in[i] = $urandom;
    for (int i = 0; i < 10; i++) m_w[i] = $urandom;
    load_inputs(150);
    load_weights(10);
    configure(20, 10, 120, 10, 15);
    axi_write(16'h0000, 32'h1);
    repeat (60) @(negedge clk);
    check("busy_before_reset", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("busy_after_reset", {31'b0, busy}, 32'd0);
    rst = 1'b0;
    read_check("reg_cleared_by_reset", 16'h0020, 32'd0);
    configure(20, 10, 120, 10, 15);
    run_model(20, 10, 120, 10, 15);
    axi_write(16'h0000, 32'h1);
    wait_idle(3000);
    check_results();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
